// File: rtl/int_pkg.sv
// int_pkg: shared interrupt sequencer state type and instruction constants
package int_pkg;
  localparam int VEC_W = 3;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] JUMP_BASE_DEF = 32'hA000_0000;
  typedef enum logic [2:0] {IDLE, ACK, DRAIN, JUMP, SERVICE, RESTORE} int_seq_state_t;
endpackage

// File: rtl/int_timeout_ctr.sv
// int_timeout_ctr: saturating service-timeout counter with clear, enable and hit
module int_timeout_ctr #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LIM = W'(MAX);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LIM) cnt <= cnt + W'(1);
  assign hit = cnt == LIM;
endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: drives pipeline through interrupt entry (stall, drain, jump) and exit (restore)
module int_sequencer
  import int_pkg::*;
#(
  parameter int          NOP_COUNT   = 5,
  parameter logic [31:0] JUMP_BASE   = JUMP_BASE_DEF,
  parameter int          TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             int_req,
  input  logic [VEC_W-1:0] int_vec,
  input  logic             int_enable,
  input  logic [31:0]      fetch_pc,
  input  logic             rti_retire,
  output logic             int_ack,
  output logic             fetch_stall,
  output logic             inj_valid,
  output logic [31:0]      inj_instr,
  output logic [31:0]      epc,
  output logic             pc_restore,
  output logic             int_done,
  output logic             busy,
  output logic             int_timeout
);
  localparam logic [3:0] DRAIN_LAST = 4'(NOP_COUNT - 1);
  int_seq_state_t state;
  logic [3:0] drain_cnt;
  logic [VEC_W-1:0] vec_q;
  logic timeout_q;
  logic hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      drain_cnt <= '0;
      vec_q <= '0;
      epc <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (int_req && int_enable) begin
          state <= ACK;
          vec_q <= int_vec;
          epc <= fetch_pc;
        end
        ACK: begin
          drain_cnt <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 4'd1;
          if (drain_cnt == DRAIN_LAST) state <= JUMP;
        end
        JUMP: state <= SERVICE;
        SERVICE: begin
          if (hit) timeout_q <= 1'b1;
          if (rti_retire) state <= RESTORE;
        end
        RESTORE: begin
          timeout_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  generate
    if (TIMEOUT_CYC != 0) begin : g_tmo
      int_timeout_ctr #(.MAX(TIMEOUT_CYC)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!(state == JUMP || state == SERVICE)),
        .en    (state == JUMP || state == SERVICE),
        .hit   (hit)
      );
    end else begin : g_no_tmo
      assign hit = 1'b0;
    end
  endgenerate
  assign int_ack     = state == ACK;
  assign fetch_stall = state == ACK || state == DRAIN || state == JUMP;
  assign inj_valid   = state == DRAIN || state == JUMP;
  assign inj_instr   = state == JUMP ? (JUMP_BASE | {{(31 - VEC_W){1'b0}}, vec_q, 1'b0}) : INSTR_NOP;
  assign pc_restore  = state == RESTORE;
  assign int_done    = state == RESTORE;
  assign busy        = state != IDLE;
  assign int_timeout = timeout_q | (state == SERVICE && hit);
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: randomized scoreboard bench for int_sequencer
module tb_int_sequencer;
  localparam int N = 5;
  localparam int TO = 8;
  localparam int NT = 30;
  typedef struct {
    logic [2:0]  vec;
    logic [31:0] pc;
    logic [31:0] jump;
    int          t_acc;
    int          t_done;
    int          tmo_at;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic int_req = 1'b0;
  logic int_enable = 1'b0;
  logic rti_retire = 1'b0;
  logic [2:0] int_vec = '0;
  logic [31:0] fetch_pc = '0;
  logic int_ack, fetch_stall, inj_valid, pc_restore, int_done, busy, int_timeout;
  logic [31:0] inj_instr, epc;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  logic [2:0] vs[NT];
  logic [31:0] pcs[NT];
  int ls[NT];
  bit b2b[NT];
  int_sequencer #(.NOP_COUNT(N), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .int_req     (int_req),
    .int_vec     (int_vec),
    .int_enable  (int_enable),
    .fetch_pc    (fetch_pc),
    .rti_retire  (rti_retire),
    .int_ack     (int_ack),
    .fetch_stall (fetch_stall),
    .inj_valid   (inj_valid),
    .inj_instr   (inj_instr),
    .epc         (epc),
    .pc_restore  (pc_restore),
    .int_done    (int_done),
    .busy        (busy),
    .int_timeout (int_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] all_outs();
    return {24'b0, int_ack, fetch_stall, inj_valid, pc_restore, int_done, busy, int_timeout, inj_instr != 32'h0};
  endfunction
  initial begin
    exp_t e;
    bit act_on, bad, tmo_drop;
    int ack_c, nops, jump_c, svc, tmo_first, ph;
    logic [31:0] epc_v, jump_v;
    act_on = 0; bad = 0; tmo_drop = 0;
    ack_c = 0; nops = 0; jump_c = 0; svc = 0; tmo_first = 0; ph = 0;
    epc_v = '0; jump_v = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) act_on = 0;
      else if (int_done) begin
        chk("txn_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ack_cycle", 32'(ack_c), 32'(e.t_acc));
          chk("nop_count", 32'(nops), 32'(N));
          chk("jump_instr", jump_v, e.jump);
          chk("jump_cycle", 32'(jump_c), 32'(e.t_acc + N + 1));
          chk("epc", epc_v, e.pc);
          chk("done_cycle", 32'(cyc), 32'(e.t_done));
          chk("restore_pulse", 32'(pc_restore), 32'd1);
          chk("timeout_rise", 32'(tmo_first), 32'(e.tmo_at));
          chk("timeout_sticky", 32'(tmo_drop), 32'd0);
          chk("protocol", 32'(bad | fetch_stall | inj_valid | !busy | !act_on), 32'd0);
        end
        act_on = 0;
      end else if (int_ack) begin
        if (act_on) bad = 1;
        else begin
          act_on = 1; ph = 1; ack_c = cyc; epc_v = epc; nops = 0; svc = 0;
          tmo_first = 0; tmo_drop = 0; jump_v = '0; jump_c = 0;
          bad = !fetch_stall || !busy || inj_valid;
        end
      end else if (act_on) begin
        if (epc !== epc_v) bad = 1;
        if (ph == 1) begin
          if (!(fetch_stall && inj_valid && busy) || pc_restore) bad = 1;
          if (inj_instr == 32'h0) nops++;
          else begin
            jump_v = inj_instr;
            jump_c = cyc;
            ph = 2;
          end
        end else begin
          svc++;
          if (!busy || fetch_stall || inj_valid || pc_restore) bad = 1;
          if (int_timeout && tmo_first == 0) tmo_first = svc;
          if (!int_timeout && tmo_first != 0) tmo_drop = 1;
        end
      end else chk("idle_outputs", all_outs(), 32'd0);
      if (exp_q.size() != 0 && cyc > exp_q[0].t_done + 4) begin
        chk("done_by_deadline", 32'(cyc), 32'(exp_q[0].t_done));
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic gap(input int g);
    for (int k = 0; k < g; k++) begin
      @(negedge clk);
      int_req = 1'($urandom_range(0, 1));
      int_enable = int_req ? 1'b0 : 1'($urandom_range(0, 1));
      int_vec = 3'($urandom);
      fetch_pc = $urandom;
      rti_retire = ($urandom_range(0, 2) == 0);
    end
  endtask
  task automatic run_txn(input int i);
    int t, l;
    bit nb, stray;
    l = ls[i];
    nb = (i + 1 < NT) && b2b[i + 1];
    stray = (i == 0) || ($urandom_range(0, 1) == 1);
    @(negedge clk);
    int_req = 1'b1; int_enable = 1'b1; int_vec = vs[i]; fetch_pc = pcs[i]; rti_retire = 1'b0;
    t = cyc + 1;
    exp_q.push_back('{vec: vs[i], pc: pcs[i], jump: 32'hA000_0000 | (32'(vs[i]) << 1),
                      t_acc: t, t_done: t + N + 2 + l, tmo_at: (l >= TO) ? TO : 0});
    for (int c = t; c <= t + N + 2 + l; c++) begin
      @(negedge clk);
      int_req = 1'($urandom_range(0, 1));
      int_enable = 1'($urandom_range(0, 1));
      int_vec = 3'($urandom);
      fetch_pc = $urandom;
      rti_retire = (c == t + N + 1 + l) || (stray && c <= t + N + 1 && (i == 0 || $urandom_range(0, 1) == 1));
      if (nb && c >= t + N + 2) begin
        int_req = 1'b1; int_enable = 1'b1; int_vec = vs[i + 1];
      end
      if (c == t + N + 2 + l) begin
        rti_retire = 1'b0;
        if (!nb) int_req = 1'b0;
      end
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
  initial begin
    for (int i = 0; i < NT; i++) begin
      vs[i] = 3'($urandom);
      pcs[i] = $urandom;
      ls[i] = $urandom_range(1, 12);
      b2b[i] = ($urandom_range(0, 3) == 0);
    end
    vs[0] = 3'd3; pcs[0] = 32'h0000_0120; ls[0] = 4; b2b[0] = 0;
    vs[1] = 3'd1; ls[1] = 6; b2b[1] = 0;
    vs[2] = 3'd5; b2b[2] = 1;
    vs[3] = 3'd7; ls[3] = 12; b2b[3] = 0;
    ls[4] = 8; b2b[4] = 0;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_epc", epc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      int_req = 1'b1; int_enable = 1'b0; int_vec = 3'($urandom); rti_retire = (k % 5 == 0);
    end
    @(negedge clk);
    int_req = 1'b0; rti_retire = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (!b2b[i]) gap($urandom_range(1, 3));
      run_txn(i);
    end
    gap(2);
    @(negedge clk);
    int_req = 1'b1; int_enable = 1'b1; int_vec = 3'd2; fetch_pc = 32'h5555_0000; rti_retire = 1'b0;
    @(negedge clk);
    int_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_drain", 32'({inj_valid, fetch_stall, inj_instr == 32'h0}), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 32'd0);
    chk("async_reset_epc", epc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_outputs", all_outs(), 32'd0);
    chk("post_reset_epc", epc, 32'd0);
    gap(1);
    run_txn(NT - 1);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
